texture_read_arbiter: RTL and testbench

Shares the single read port of the GPU texture RAM (registered `raddr` in, `rcolor` valid one cycle later) among `N_REQ` rendering requesters. Each requester runs a valid/ready address handshake. The block grants round-robin, tracks every in-flight read with a requester ID and returns colors in issue order on one shared response channel. A small response FIFO absorbs response backpressure, and credit-based issue guarantees the FIFO never overflows.

---
 rtl/gpu_pkg.sv | 20 ++
 rtl/tex_rsp_fifo.sv | 69 ++++++
 rtl/texture_read_arbiter.sv | 132 +++++++++++++
 tb/tb_texture_read_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// Shared types for the texture read path: the response record that travels
// from the texture RAM pipeline through the response FIFO.
package gpu_pkg;

    localparam int TEX_N_REQ       = 4;
    localparam int TEX_COLOR_WIDTH = 12;

    // Requester ID width; a lone requester still needs one bit to carry an ID.
    function automatic int id_width(input int n_req);
        return (n_req > 1) ? $clog2(n_req) : 1;
    endfunction

    localparam int TEX_ID_WIDTH = id_width(TEX_N_REQ);

    typedef struct packed {
        logic [TEX_ID_WIDTH-1:0]    id;
        logic [TEX_COLOR_WIDTH-1:0] color;
    } tex_rsp_t;

endpackage

// File: rtl/tex_rsp_fifo.sv
// First-word-fall-through response FIFO. The head reads as zero while empty so
// the response channel shows clean zeros whenever nothing is pending.
module tex_rsp_fifo
    import gpu_pkg::*;
#(
    parameter int  RSP_DEPTH = 4,
    parameter type entry_t   = tex_rsp_t,
    localparam int CNT_W     = $clog2(RSP_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  entry_t           push_data,
    input  logic             pop,
    output entry_t           head,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

    entry_t           mem [RSP_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             full;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty  = (count_reg == '0);
    assign full   = (count_reg == CNT_W'(RSP_DEPTH));
    assign do_pop = pop && !empty;
    assign count  = count_reg;
    assign head   = empty ? '0 : mem[rd_ptr_reg];

    // Storage carries no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (do_pop) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            case ({push, do_pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Issue credits must keep the FIFO from ever being pushed while full.
    assert property (@(posedge clk) disable iff (!rst_n) !(push && full));

endmodule

// File: rtl/texture_read_arbiter.sv
// Round-robin arbiter sharing the texture RAM read port among N_REQ requesters;
// in-flight reads are tagged and returned in issue order through a credited FIFO.
module texture_read_arbiter
    import gpu_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int ADDR_WIDTH  = 22,
    parameter int COLOR_WIDTH = 12,
    parameter int RSP_DEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_REQ-1:0]            req_valid,
    output logic [N_REQ-1:0]            req_ready,
    input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [$clog2(N_REQ)-1:0]    rsp_id,
    output logic [COLOR_WIDTH-1:0]      rsp_color,
    output logic [ADDR_WIDTH-1:0]       raddr,
    input  logic [COLOR_WIDTH-1:0]      rcolor
);

    localparam int ID_W  = id_width(N_REQ);
    localparam int CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int OUT_W = $clog2(RSP_DEPTH + 3);

    typedef struct packed {
        logic [ID_W-1:0]        id;
        logic [COLOR_WIDTH-1:0] color;
    } rsp_t;

    logic [ADDR_WIDTH-1:0] addr_slice [N_REQ];
    logic [ID_W-1:0]       rr_reg;
    logic [ID_W-1:0]       rr_next;
    logic [ID_W-1:0]       tag1_reg;
    logic [ID_W-1:0]       tag2_reg;
    logic                  v1_reg;
    logic                  v2_reg;
    logic [ID_W:0]         cand_sum;
    logic [ID_W-1:0]       cand_idx;
    logic [ID_W-1:0]       grant_idx;
    logic                  grant_found;
    logic                  credit_ok;
    logic                  xfer;
    logic [CNT_W-1:0]      fifo_count;
    logic [OUT_W-1:0]      outstanding;
    logic                  fifo_empty;
    rsp_t                  push_data;
    rsp_t                  head;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_addr
            assign addr_slice[gi] = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
        end
    endgenerate

    // Credits count every read that will eventually land in the FIFO; a pop
    // only frees a slot once the count register has actually dropped.
    assign outstanding = OUT_W'(v1_reg) + OUT_W'(v2_reg) + OUT_W'(fifo_count);
    assign credit_ok   = rst_n && (outstanding < OUT_W'(RSP_DEPTH));

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand_sum    = '0;
        cand_idx    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand_sum = {1'b0, rr_reg} + (ID_W+1)'(k);
            if (cand_sum >= (ID_W+1)'(N_REQ)) begin
                cand_sum = cand_sum - (ID_W+1)'(N_REQ);
            end
            cand_idx = cand_sum[ID_W-1:0];
            if (!grant_found && req_valid[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    assign xfer    = grant_found && credit_ok;
    assign rr_next = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;

    always_comb begin
        req_ready = '0;
        if (xfer) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_reg   <= '0;
            raddr    <= '0;
            tag1_reg <= '0;
            tag2_reg <= '0;
            v1_reg   <= 1'b0;
            v2_reg   <= 1'b0;
        end else begin
            v1_reg   <= xfer;
            v2_reg   <= v1_reg;
            tag2_reg <= tag1_reg;
            if (xfer) begin
                rr_reg   <= rr_next;
                raddr    <= addr_slice[grant_idx];
                tag1_reg <= grant_idx;
            end
        end
    end

    assign push_data.id    = tag2_reg;
    assign push_data.color = rcolor;

    tex_rsp_fifo #(
        .RSP_DEPTH (RSP_DEPTH),
        .entry_t   (rsp_t)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (v2_reg),
        .push_data (push_data),
        .pop       (rsp_ready),
        .head      (head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign rsp_valid = !fifo_empty;
    assign rsp_id    = head.id;
    assign rsp_color = head.color;

endmodule

// File: tb/tb_texture_read_arbiter.sv
// Directed and random bench for texture_read_arbiter with a texture RAM model
// (mem[a] = a[11:0] ^ 12'hA5A) and an issue-order response scoreboard.
`timescale 1ns/1ps
module tb_texture_read_arbiter;

    localparam int N_REQ       = 4;
    localparam int ADDR_WIDTH  = 22;
    localparam int COLOR_WIDTH = 12;
    localparam int RSP_DEPTH   = 4;
    localparam int ID_W        = 2;

    logic                        clk = 1'b0;
    logic                        rst_n = 1'b0;
    logic [N_REQ-1:0]            req_valid = '0;
    logic [N_REQ-1:0]            req_ready;
    logic [N_REQ*ADDR_WIDTH-1:0] req_addr = '0;
    logic                        rsp_valid;
    logic                        rsp_ready = 1'b1;
    logic [ID_W-1:0]             rsp_id;
    logic [COLOR_WIDTH-1:0]      rsp_color;
    logic [ADDR_WIDTH-1:0]       raddr;
    logic [COLOR_WIDTH-1:0]      rcolor = '0;

    typedef struct packed {
        logic [ID_W-1:0]        id;
        logic [COLOR_WIDTH-1:0] color;
    } exp_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int accepts = 0;
    int responses = 0;
    logic [COLOR_WIDTH-1:0] last_rsp_color = '0;
    exp_t sb [$];
    logic [ADDR_WIDTH-1:0] addr_q [N_REQ][$];
    int grant_log [$];
    int grant_cyc [$];
    int rsp_cyc [$];
    int exp_rr [5] = '{0, 1, 2, 3, 0};

    texture_read_arbiter #(
        .N_REQ       (N_REQ),
        .ADDR_WIDTH  (ADDR_WIDTH),
        .COLOR_WIDTH (COLOR_WIDTH),
        .RSP_DEPTH   (RSP_DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_color (rsp_color),
        .raddr     (raddr),
        .rcolor    (rcolor)
    );

    always #5 clk = ~clk;

    function automatic logic [COLOR_WIDTH-1:0] tex_mem(input logic [ADDR_WIDTH-1:0] a);
        return a[11:0] ^ 12'hA5A;
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] addr_of(input int i);
        return ADDR_WIDTH'(req_addr >> (i * ADDR_WIDTH));
    endfunction

    always @(posedge clk) begin
        cyc++;
        rcolor <= tex_mem(raddr);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor: scoreboard push on accept, pop/compare on response transfer.
    always @(negedge clk) begin
        if (rst_n) begin
            exp_t e;
            chk("req_ready_onehot0", 64'($onehot0(req_ready)), 64'd1);
            chk("req_ready_without_valid", 64'(req_ready & ~req_valid), 64'd0);
            chk("outstanding_within_depth", 64'(sb.size() <= RSP_DEPTH), 64'd1);
            for (int i = 0; i < N_REQ; i++) begin
                if (req_valid[i[ID_W-1:0]] && req_ready[i[ID_W-1:0]]) begin
                    e.id    = i[ID_W-1:0];
                    e.color = tex_mem(addr_of(i));
                    sb.push_back(e);
                    grant_log.push_back(i);
                    grant_cyc.push_back(cyc);
                    accepts++;
                    $display("cycle %0d: accept req %0d addr 0x%0h", cyc, i, addr_of(i));
                end
            end
            if (rsp_valid && rsp_ready) begin
                responses++;
                rsp_cyc.push_back(cyc);
                last_rsp_color = rsp_color;
                $display("cycle %0d: response id %0d color 0x%0h", cyc, rsp_id, rsp_color);
                chk("response_expected", 64'(sb.size() > 0), 64'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("rsp_id", 64'(rsp_id), 64'(e.id));
                    chk("rsp_color", 64'(rsp_color), 64'(e.color));
                end
            end
        end
    end

    function automatic logic any_pending();
        for (int i = 0; i < N_REQ; i++) begin
            if (addr_q[i[ID_W-1:0]].size() > 0) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic present();
        logic [N_REQ*ADDR_WIDTH-1:0] flat;
        flat = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (addr_q[i[ID_W-1:0]].size() > 0) begin
                req_valid[i[ID_W-1:0]] = 1'b1;
                flat = flat | ((N_REQ*ADDR_WIDTH)'(addr_q[i[ID_W-1:0]][0]) << (i * ADDR_WIDTH));
            end else begin
                req_valid[i[ID_W-1:0]] = 1'b0;
            end
        end
        req_addr = flat;
    endtask

    task automatic cycle();
        logic [N_REQ-1:0] fire;
        @(negedge clk);
        fire = req_valid & req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < N_REQ; i++) begin
            if (fire[i[ID_W-1:0]]) void'(addr_q[i[ID_W-1:0]].pop_front());
        end
    endtask

    task automatic run_until_idle(input int max_cycles, output int used);
        used = 0;
        present();
        while (any_pending() && used < max_cycles) begin
            cycle();
            used++;
            present();
        end
        chk("issue_within_budget", 64'(any_pending()), 64'd0);
    endtask

    task automatic wait_drain(input int max_cycles);
        int n = 0;
        while (sb.size() > 0 && n < max_cycles) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_within_budget", 64'(sb.size()), 64'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sb.delete();
        for (int i = 0; i < N_REQ; i++) addr_q[i[ID_W-1:0]].delete();
        present();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int used;
        int base_acc;
        int base_rsp;
        int g0;

        // Reset values, with a request already pending.
        addr_q[1].push_back(22'h123);
        present();
        #2;
        chk("reset_req_ready", 64'(req_ready), 64'd0);
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_rsp_id", 64'(rsp_id), 64'd0);
        chk("reset_rsp_color", 64'(rsp_color), 64'd0);
        chk("reset_raddr", 64'(raddr), 64'd0);
        do_reset();

        // Single request: requester 2, addr 0x010.
        addr_q[2].push_back(22'h010);
        base_acc = accepts;
        base_rsp = responses;
        present();
        cycle();
        present();
        chk("single_accepted", 64'(accepts - base_acc), 64'd1);
        @(posedge clk); #1;
        chk("single_rsp_not_yet", 64'(rsp_valid), 64'd0);
        @(posedge clk); #1;
        chk("single_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("single_rsp_id", 64'(rsp_id), 64'd2);
        chk("single_rsp_color", 64'(rsp_color), 64'hA4A);
        wait_drain(10);
        chk("single_rsp_count", 64'(responses - base_rsp), 64'd1);

        // Round-robin from rr=0 with all requesters valid.
        do_reset();
        grant_log.delete(); grant_cyc.delete(); rsp_cyc.delete();
        addr_q[0].push_back(22'h100);
        addr_q[0].push_back(22'h100);
        addr_q[1].push_back(22'h101);
        addr_q[2].push_back(22'h102);
        addr_q[3].push_back(22'h103);
        run_until_idle(20, used);
        chk("rr_issue_cycles", 64'(used), 64'd5);
        wait_drain(20);
        for (int k = 0; k < 5; k++) begin
            chk("rr_grant_order", 64'(grant_log[k]), 64'(exp_rr[k]));
            chk("rr_grant_back_to_back", 64'(grant_cyc[k] - grant_cyc[0]), 64'(k));
            chk("rr_rsp_back_to_back", 64'(rsp_cyc[k] - rsp_cyc[0]), 64'(k));
        end
        chk("rr_latency_3_edges", 64'(rsp_cyc[0] - grant_cyc[0]), 64'd3);

        // Sparse: rr=1, only requester 3 valid -> granted at once, rr wraps to 0.
        g0 = grant_log.size();
        addr_q[3].push_back(22'h333);
        run_until_idle(5, used);
        chk("sparse_immediate", 64'(used), 64'd1);
        chk("sparse_grant3", 64'(grant_log[g0]), 64'd3);
        @(posedge clk); #1;
        addr_q[0].push_back(22'h200);
        addr_q[1].push_back(22'h201);
        run_until_idle(5, used);
        chk("sparse_rr_wrapped", 64'(grant_log[g0+1]), 64'd0);
        @(posedge clk); #1;
        addr_q[0].push_back(22'h202);
        addr_q[3].push_back(22'h203);
        run_until_idle(5, used);
        chk("sparse_rr_held_over_idle", 64'(grant_log[g0+3]), 64'd3);
        wait_drain(20);

        // Backpressure: requester 1 streams with rsp_ready low.
        rsp_ready = 1'b0;
        base_acc = accepts;
        for (int k = 0; k < 8; k++) addr_q[1].push_back(ADDR_WIDTH'(22'h400 + k));
        repeat (10) begin
            present();
            cycle();
        end
        chk("bp_accepts", 64'(accepts - base_acc), 64'd4);
        chk("bp_req_ready_low", 64'(req_ready), 64'd0);
        chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
        rsp_ready = 1'b1;
        run_until_idle(50, used);
        wait_drain(50);
        chk("bp_resumed_accepts", 64'(accepts - base_acc), 64'd8);

        // Mid-stream reset with three reads in flight.
        rsp_ready = 1'b0;
        addr_q[1].push_back(22'h500);
        addr_q[1].push_back(22'h501);
        addr_q[1].push_back(22'h502);
        run_until_idle(10, used);
        rst_n = 1'b0;
        sb.delete();
        for (int i = 0; i < N_REQ; i++) addr_q[i[ID_W-1:0]].delete();
        addr_q[0].push_back(22'h000);
        present();
        #1;
        chk("midrst_req_ready", 64'(req_ready), 64'd0);
        chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("midrst_rsp_id", 64'(rsp_id), 64'd0);
        chk("midrst_rsp_color", 64'(rsp_color), 64'd0);
        chk("midrst_raddr", 64'(raddr), 64'd0);
        base_rsp = responses;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_until_idle(10, used);
        wait_drain(20);
        repeat (4) @(posedge clk);
        #1;
        chk("midrst_single_rsp", 64'(responses - base_rsp), 64'd1);
        chk("midrst_fresh_color", 64'(last_rsp_color), 64'hA5A);

        // Random soak.
        base_acc = accepts;
        base_rsp = responses;
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (addr_q[i[ID_W-1:0]].size() == 0 && $urandom_range(0, 2) == 0)
                    addr_q[i[ID_W-1:0]].push_back(ADDR_WIDTH'($urandom()));
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            present();
            cycle();
        end
        rsp_ready = 1'b1;
        run_until_idle(100, used);
        wait_drain(100);
        chk("soak_all_returned", 64'(accepts - base_acc), 64'(responses - base_rsp));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
